// File: rtl/spi_master_cs_ctrl_if.sv
// Bus bundle for spi_master_cs_ctrl: user-side byte handshake plus the
// engine-side byte/CS signals. The controller uses the slave modport; the
// surrounding logic (user + spi_master engine) uses the master modport.
interface spi_master_cs_ctrl_if #(
  parameter int MAX_BYTES_PER_CS = 2
);
  localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1);

  // user side
  logic [CNT_W-1:0] i_TX_Count;
  logic [7:0]       i_TX_Byte;
  logic             i_TX_DV;
  logic             o_TX_Ready;
  logic [CNT_W-1:0] o_RX_Count;
  logic             o_RX_DV;
  logic [7:0]       o_RX_Byte;

  // engine side
  logic [7:0]       o_SPI_TX_Byte;
  logic             o_SPI_TX_DV;
  logic             i_SPI_TX_Ready;
  logic             i_SPI_RX_DV;
  logic [7:0]       i_SPI_RX_Byte;
  logic             o_SPI_CS_n;

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV,
    input  i_SPI_TX_Ready, i_SPI_RX_DV, i_SPI_RX_Byte,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    output o_SPI_TX_Byte, o_SPI_TX_DV, o_SPI_CS_n
  );

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV,
    output i_SPI_TX_Ready, i_SPI_RX_DV, i_SPI_RX_Byte,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte,
    input  o_SPI_TX_Byte, o_SPI_TX_DV, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_master_cs_ctrl.sv
// spi_master_cs_ctrl: chip-select / transaction sequencer in front of the
// byte-level spi_master engine. Groups 1..MAX_BYTES_PER_CS bytes under one
// active-low CS, tags returned bytes with their index and holds CS high for
// a minimum gap between transactions.
//
// Optional macro SPI_CS_LEAD_EN: inserts CS_LEAD_CLKS (+1) cycles between
// the CS fall and the first engine DV. Without it CS falls together with the
// first engine DV.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | CS high, waiting for the first byte of a transaction
// LEAD  | CS low, counting down lead time before first DV (SPI_CS_LEAD_EN)
// XFER  | CS low, forwarding bytes and collecting engine RX bytes
// GAP   | CS high, enforcing the minimum CS-inactive time
module spi_master_cs_ctrl #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 4
`ifdef SPI_CS_LEAD_EN
  ,
  parameter int CS_LEAD_CLKS     = 2
`endif
) (
  input logic                 i_Clk,
  input logic                 i_RST_L,
  spi_master_cs_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int GAP_W = (CS_INACTIVE_CLKS < 2) ? 1 : $clog2(CS_INACTIVE_CLKS + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BYTES_PER_CS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_INACTIVE_CLKS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

`ifdef SPI_CS_LEAD_EN
  localparam int LEAD_W = (CS_LEAD_CLKS < 2) ? 1 : $clog2(CS_LEAD_CLKS + 1);
  localparam logic [LEAD_W-1:0] LEAD_LOAD = LEAD_W'(CS_LEAD_CLKS);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
`ifdef SPI_CS_LEAD_EN
    ,
    ST_LEAD = 2'd3
`endif
  } state_t;

  state_t state, state_nxt;

  logic             cs_n_q;
  logic             spi_tx_dv_q;
  logic [7:0]       spi_tx_byte_q;
  logic             rx_dv_q;
  logic [7:0]       rx_byte_q;
  logic [CNT_W-1:0] rx_count_q;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] rx_idx;
  logic [CNT_W-1:0] cnt_clamped;
  logic [GAP_W-1:0] gap_cnt;
`ifdef SPI_CS_LEAD_EN
  logic [LEAD_W-1:0] lead_cnt;
`endif

  logic tx_ready;
  logic ld_first;
  logic ld_next;
  logic xfer_done;
  logic tx_dv_set;
  logic rx_take;

  // requested byte count: 0 means one byte, oversize requests clamp to max
  always_comb begin
    cnt_clamped = bus.i_TX_Count;
    if (bus.i_TX_Count == '0) begin
      cnt_clamped = CNT_ONE;
    end else if (bus.i_TX_Count > CNT_MAX) begin
      cnt_clamped = CNT_MAX;
    end
  end

  // next-state decode, accept strobes and the combinational ready
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    ld_first  = 1'b0;
    ld_next   = 1'b0;
    xfer_done = 1'b0;
    tx_dv_set = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_ready = 1'b1;
        if (bus.i_TX_DV) begin
          ld_first = 1'b1;
`ifdef SPI_CS_LEAD_EN
          if (CS_LEAD_CLKS == 0) begin
            tx_dv_set = 1'b1;
            state_nxt = ST_XFER;
          end else begin
            state_nxt = ST_LEAD;
          end
`else
          tx_dv_set = 1'b1;
          state_nxt = ST_XFER;
`endif
        end
      end
`ifdef SPI_CS_LEAD_EN
      ST_LEAD: begin
        if (lead_cnt == '0) begin
          tx_dv_set = 1'b1;
          state_nxt = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        tx_ready = (remaining != '0) && bus.i_SPI_TX_Ready && !spi_tx_dv_q;
        if (tx_ready && bus.i_TX_DV) begin
          ld_next   = 1'b1;
          tx_dv_set = 1'b1;
        end else if ((remaining == '0) && (outstanding == '0) &&
                     bus.i_SPI_TX_Ready && !spi_tx_dv_q) begin
          xfer_done = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_ONE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // never advertise ready while reset is being applied
    if (!i_RST_L) begin
      tx_ready = 1'b0;
    end
  end

  // engine RX pulses only count while a transaction is open
  assign rx_take = bus.i_SPI_RX_DV && (state == ST_XFER);

  // state register
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // chip select and engine-side byte/strobe
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      cs_n_q        <= 1'b1;
      spi_tx_dv_q   <= 1'b0;
      spi_tx_byte_q <= 8'h00;
    end else begin
      spi_tx_dv_q <= tx_dv_set;
      if (ld_first || ld_next) begin
        spi_tx_byte_q <= bus.i_TX_Byte;
      end
      if (ld_first) begin
        cs_n_q <= 1'b0;
      end else if (xfer_done) begin
        cs_n_q <= 1'b1;
      end
    end
  end

  // bytes still to accept and the RX index within the transaction
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      remaining <= '0;
      rx_idx    <= '0;
    end else begin
      if (ld_first) begin
        remaining <= cnt_clamped - CNT_ONE;
      end else if (ld_next) begin
        remaining <= remaining - CNT_ONE;
      end
      if (ld_first) begin
        rx_idx <= '0;
      end else if (rx_take) begin
        rx_idx <= rx_idx + CNT_ONE;
      end
    end
  end

  // bytes handed to the engine but not yet returned; accept and RX may coincide
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      outstanding <= '0;
    end else if (ld_first) begin
      outstanding <= CNT_ONE;
    end else begin
      case ({ld_next, rx_take && (outstanding != '0)})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // CS-inactive gap down-counter, loaded as CS rises
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      gap_cnt <= '0;
    end else if (xfer_done) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - GAP_ONE;
    end
  end

`ifdef SPI_CS_LEAD_EN
  // CS-to-first-DV lead down-counter, loaded as CS falls
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      lead_cnt <= '0;
    end else if (ld_first) begin
      lead_cnt <= LEAD_LOAD;
    end else if ((state == ST_LEAD) && (lead_cnt != '0)) begin
      lead_cnt <= lead_cnt - LEAD_W'(1);
    end
  end
`endif

  // registered copy of engine RX, tagged with its index
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      rx_dv_q    <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_count_q <= '0;
    end else begin
      rx_dv_q <= rx_take;
      if (rx_take) begin
        rx_byte_q  <= bus.i_SPI_RX_Byte;
        rx_count_q <= rx_idx;
      end
    end
  end

  assign bus.o_TX_Ready    = tx_ready;
  assign bus.o_RX_Count    = rx_count_q;
  assign bus.o_RX_DV       = rx_dv_q;
  assign bus.o_RX_Byte     = rx_byte_q;
  assign bus.o_SPI_TX_Byte = spi_tx_byte_q;
  assign bus.o_SPI_TX_DV   = spi_tx_dv_q;
  assign bus.o_SPI_CS_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_cs_ctrl.sv
// Directed bench for spi_master_cs_ctrl. A small behavioural engine model
// loops MOSI back to MISO: each engine DV makes it busy for ENG_LAT cycles,
// then it returns the same byte with a one-cycle RX pulse.
module tb_spi_master_cs_ctrl;

  localparam int ENG_LAT = 20;
`ifdef SPI_CS_LEAD_EN
  localparam int EXP_LEAD = 3;
`else
  localparam int EXP_LEAD = 0;
`endif

  logic clk = 1'b0;
  logic rst_l = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  spi_master_cs_ctrl_if bus ();

  spi_master_cs_ctrl dut (
    .i_Clk  (clk),
    .i_RST_L(rst_l),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // monitor state
  int cyc = 0;
  int falls = 0, rises = 0, dv_cnt = 0;
  int t_fall = 0, t_rise = 0, t_first_dv = 0, t_ready = 0;
  bit first_pend = 0, ready_wait = 0, ready_seen = 0;
  logic [7:0] q_b[$];
  logic [1:0] q_c[$];

  // engine model state
  bit         eng_busy = 0;
  int         eng_cnt = 0;
  logic [7:0] eng_byte = 8'h00;

  initial begin
    bus.i_SPI_TX_Ready = 1'b1;
    bus.i_SPI_RX_DV    = 1'b0;
    bus.i_SPI_RX_Byte  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_l !== 1'b1) begin
        eng_busy = 0;
        bus.i_SPI_TX_Ready = 1'b1;
        bus.i_SPI_RX_DV    = 1'b0;
      end else begin
        bus.i_SPI_RX_DV = 1'b0;
        if (eng_busy) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus.i_SPI_RX_DV    = 1'b1;
            bus.i_SPI_RX_Byte  = eng_byte;
            bus.i_SPI_TX_Ready = 1'b1;
            eng_busy = 0;
          end
        end else if (bus.o_SPI_TX_DV === 1'b1) begin
          eng_busy = 1;
          eng_byte = bus.o_SPI_TX_Byte;
          eng_cnt  = ENG_LAT;
          bus.i_SPI_TX_Ready = 1'b0;
        end
      end
    end
  end

  initial begin
    logic cs_prev;
    cs_prev = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (cs_prev === 1'b1 && bus.o_SPI_CS_n === 1'b0) begin
        falls++;
        t_fall = cyc;
        first_pend = 1;
      end
      if (cs_prev === 1'b0 && bus.o_SPI_CS_n === 1'b1) begin
        rises++;
        t_rise = cyc;
        ready_wait = 1;
        ready_seen = 0;
      end
      if (bus.o_SPI_TX_DV === 1'b1) begin
        dv_cnt++;
        if (first_pend) begin
          t_first_dv = cyc;
          first_pend = 0;
        end
      end
      if (ready_wait && bus.o_TX_Ready === 1'b1) begin
        t_ready = cyc;
        ready_wait = 0;
        ready_seen = 1;
      end
      if (bus.o_RX_DV === 1'b1) begin
        q_b.push_back(bus.o_RX_Byte);
        q_c.push_back(bus.o_RX_Count);
      end
      cs_prev = bus.o_SPI_CS_n;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_mon();
    falls = 0; rises = 0; dv_cnt = 0;
    first_pend = 0; ready_wait = 0; ready_seen = 0;
    q_b.delete();
    q_c.delete();
  endtask

  task automatic send(input logic [1:0] cnt, input logic [7:0] b);
    int n;
    n = 0;
    while (bus.o_TX_Ready !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      $display("FAIL send_timeout: o_TX_Ready=%b required 1", bus.o_TX_Ready);
    end
    bus.i_TX_Count = cnt;
    bus.i_TX_Byte  = b;
    bus.i_TX_DV    = 1'b1;
    tick();
    bus.i_TX_DV    = 1'b0;
  endtask

  task automatic wait_done(input int exp_rises);
    int n;
    n = 0;
    while (!(rises >= exp_rises && ready_seen) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL done_timeout: rises=%0d required %0d", rises, exp_rises);
    end
  endtask

  function automatic logic [7:0] rxb(input int i);
    return (q_b.size() > i) ? q_b[i] : 8'hxx;
  endfunction

  function automatic logic [1:0] rxc(input int i);
    return (q_c.size() > i) ? q_c[i] : 2'bxx;
  endfunction

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.o_SPI_CS_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", bus.o_SPI_CS_n); else n_pass++;
    n_checks++; if (bus.o_SPI_TX_DV !== 1'b0) $display("FAIL reset_spi_dv: got %b want 0", bus.o_SPI_TX_DV); else n_pass++;
    n_checks++; if (bus.o_SPI_TX_Byte !== 8'h00) $display("FAIL reset_spi_byte: got %h want 00", bus.o_SPI_TX_Byte); else n_pass++;
    n_checks++; if (bus.o_RX_DV !== 1'b0) $display("FAIL reset_rx_dv: got %b want 0", bus.o_RX_DV); else n_pass++;
    n_checks++; if (bus.o_RX_Byte !== 8'h00) $display("FAIL reset_rx_byte: got %h want 00", bus.o_RX_Byte); else n_pass++;
    n_checks++; if (bus.o_RX_Count !== 2'd0) $display("FAIL reset_rx_count: got %0d want 0", bus.o_RX_Count); else n_pass++;
    n_checks++; if (bus.o_TX_Ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.o_TX_Ready); else n_pass++;
    rst_l = 1'b1;
    #1;
    n_checks++; if (bus.o_TX_Ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.o_TX_Ready); else n_pass++;
    tick();
  endtask

  task automatic test_single();
    clr_mon();
    send(2'd1, 8'hC1);
    wait_done(1);
    n_checks++; if (falls !== 1) $display("FAIL single_falls: got %0d want 1", falls); else n_pass++;
    n_checks++; if (dv_cnt !== 1) $display("FAIL single_dv_cnt: got %0d want 1", dv_cnt); else n_pass++;
    n_checks++; if (q_b.size() !== 1) $display("FAIL single_rx_n: got %0d want 1", q_b.size()); else n_pass++;
    n_checks++; if (rxb(0) !== 8'hC1) $display("FAIL single_rx_byte: got %h want c1", rxb(0)); else n_pass++;
    n_checks++; if (rxc(0) !== 2'd0) $display("FAIL single_rx_count: got %0d want 0", rxc(0)); else n_pass++;
    n_checks++; if (t_ready - t_rise !== 4) $display("FAIL single_gap: got %0d want 4", t_ready - t_rise); else n_pass++;
    n_checks++; if (t_first_dv - t_fall !== EXP_LEAD) $display("FAIL single_lead: got %0d want %0d", t_first_dv - t_fall, EXP_LEAD); else n_pass++;
  endtask

  task automatic test_two_byte();
    clr_mon();
    send(2'd2, 8'hBE);
    n_checks++; if (bus.o_TX_Ready !== 1'b0) $display("FAIL two_ready_after_first: got %b want 0", bus.o_TX_Ready); else n_pass++;
    repeat (6) tick();
    n_checks++; if (bus.o_TX_Ready !== 1'b0) $display("FAIL two_ready_busy: got %b want 0", bus.o_TX_Ready); else n_pass++;
    n_checks++; if (bus.o_SPI_CS_n !== 1'b0) $display("FAIL two_cs_held: got %b want 0", bus.o_SPI_CS_n); else n_pass++;
    send(2'd2, 8'hEF);
    wait_done(1);
    n_checks++; if (falls !== 1) $display("FAIL two_falls: got %0d want 1", falls); else n_pass++;
    n_checks++; if (rises !== 1) $display("FAIL two_rises: got %0d want 1", rises); else n_pass++;
    n_checks++; if (dv_cnt !== 2) $display("FAIL two_dv_cnt: got %0d want 2", dv_cnt); else n_pass++;
    n_checks++; if (rxb(0) !== 8'hBE || rxc(0) !== 2'd0) $display("FAIL two_rx0: got %h/%0d want be/0", rxb(0), rxc(0)); else n_pass++;
    n_checks++; if (rxb(1) !== 8'hEF || rxc(1) !== 2'd1) $display("FAIL two_rx1: got %h/%0d want ef/1", rxb(1), rxc(1)); else n_pass++;
    n_checks++; if (t_first_dv - t_fall !== EXP_LEAD) $display("FAIL two_lead: got %0d want %0d", t_first_dv - t_fall, EXP_LEAD); else n_pass++;
  endtask

  task automatic test_count_bounds();
    clr_mon();
    send(2'd0, 8'h5A);
    wait_done(1);
    n_checks++; if (q_b.size() !== 1 || rxb(0) !== 8'h5A || rxc(0) !== 2'd0) $display("FAIL zero_cnt_rx: got n=%0d %h/%0d want n=1 5a/0", q_b.size(), rxb(0), rxc(0)); else n_pass++;
    n_checks++; if (dv_cnt !== 1) $display("FAIL zero_cnt_dv: got %0d want 1", dv_cnt); else n_pass++;
    clr_mon();
    send(2'd3, 8'h11);
    send(2'd3, 8'h22);
    wait_done(1);
    n_checks++; if (rises !== 1 || falls !== 1) $display("FAIL clamp_cs: got falls=%0d rises=%0d want 1/1", falls, rises); else n_pass++;
    n_checks++; if (rxb(0) !== 8'h11 || rxc(0) !== 2'd0) $display("FAIL clamp_rx0: got %h/%0d want 11/0", rxb(0), rxc(0)); else n_pass++;
    n_checks++; if (rxb(1) !== 8'h22 || rxc(1) !== 2'd1) $display("FAIL clamp_rx1: got %h/%0d want 22/1", rxb(1), rxc(1)); else n_pass++;
    send(2'd1, 8'h33);
    wait_done(2);
    n_checks++; if (falls !== 2) $display("FAIL clamp_new_txn_falls: got %0d want 2", falls); else n_pass++;
    n_checks++; if (rxb(2) !== 8'h33 || rxc(2) !== 2'd0) $display("FAIL clamp_rx2: got %h/%0d want 33/0", rxb(2), rxc(2)); else n_pass++;
  endtask

  task automatic test_ignored();
    int n;
    clr_mon();
    send(2'd2, 8'h61);
    repeat (3) tick();
    bus.i_TX_Byte = 8'hFF;
    bus.i_TX_DV   = 1'b1;
    tick();
    bus.i_TX_DV   = 1'b0;
    send(2'd2, 8'h62);
    n = 0;
    while (bus.o_SPI_CS_n !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    n_checks++; if (bus.o_SPI_CS_n !== 1'b1) $display("FAIL ign_cs_rise: got %b want 1", bus.o_SPI_CS_n); else n_pass++;
    n_checks++; if (bus.o_TX_Ready !== 1'b0) $display("FAIL ign_gap_ready: got %b want 0", bus.o_TX_Ready); else n_pass++;
    bus.i_TX_Count = 2'd1;
    bus.i_TX_Byte  = 8'hFF;
    bus.i_TX_DV    = 1'b1;
    repeat (2) tick();
    bus.i_TX_DV    = 1'b0;
    repeat (40) tick();
    n_checks++; if (falls !== 1) $display("FAIL ign_falls: got %0d want 1", falls); else n_pass++;
    n_checks++; if (dv_cnt !== 2) $display("FAIL ign_dv_cnt: got %0d want 2", dv_cnt); else n_pass++;
    n_checks++; if (q_b.size() !== 2) $display("FAIL ign_rx_n: got %0d want 2", q_b.size()); else n_pass++;
    n_checks++; if (rxb(0) !== 8'h61 || rxb(1) !== 8'h62) $display("FAIL ign_rx_bytes: got %h %h want 61 62", rxb(0), rxb(1)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send(2'd2, 8'h71);
    tick();
    rst_l = 1'b0;
    tick();
    n_checks++; if (bus.o_SPI_CS_n !== 1'b1) $display("FAIL rstmid_cs: got %b want 1", bus.o_SPI_CS_n); else n_pass++;
    n_checks++; if (bus.o_TX_Ready !== 1'b0) $display("FAIL rstmid_ready1: got %b want 0", bus.o_TX_Ready); else n_pass++;
    n_checks++; if (bus.o_SPI_TX_DV !== 1'b0) $display("FAIL rstmid_dv: got %b want 0", bus.o_SPI_TX_DV); else n_pass++;
    tick();
    n_checks++; if (bus.o_TX_Ready !== 1'b0) $display("FAIL rstmid_ready2: got %b want 0", bus.o_TX_Ready); else n_pass++;
    rst_l = 1'b1;
    #1;
    n_checks++; if (bus.o_TX_Ready !== 1'b1) $display("FAIL rstmid_no_gap: got %b want 1", bus.o_TX_Ready); else n_pass++;
    clr_mon();
    send(2'd1, 8'hA5);
    wait_done(1);
    n_checks++; if (q_b.size() !== 1 || rxb(0) !== 8'hA5 || rxc(0) !== 2'd0) $display("FAIL rstmid_rx: got n=%0d %h/%0d want n=1 a5/0", q_b.size(), rxb(0), rxc(0)); else n_pass++;
  endtask

  initial begin
    bus.i_TX_Count = 2'd0;
    bus.i_TX_Byte  = 8'h00;
    bus.i_TX_DV    = 1'b0;
    test_reset();
    test_single();
    test_two_byte();
    test_count_bounds();
    test_ignored();
    test_reset_mid();
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_cs_ctrl.md
Name: spi_master_cs_ctrl

Overview:
Chip-select and transaction sequencer placed in front of the byte-level spi_master engine. Groups 1..MAX_BYTES_PER_CS bytes into one transaction under a single active-low CS, forwards bytes to the engine, and tags returned bytes with their index. Enforces a minimum CS-inactive gap between transactions. Sits between user logic and spi_master and shares its clock and reset.

Parameters:
MAX_BYTES_PER_CS, 2, maximum bytes per CS assertion; CNT_W = $clog2(MAX_BYTES_PER_CS+1).
CS_INACTIVE_CLKS, 4, i_Clk cycles CS_n is held high after a transaction.
CS_LEAD_CLKS, 2, cycles from CS_n fall to the first engine DV; used only with SPI_CS_LEAD_EN.

Ports:
i_Clk  in  1  system clock.
i_RST_L  in  1  reset, synchronous, active-low; shared with spi_master.
i_TX_Count  in  CNT_W  byte count, sampled only on the first byte of a transaction.
i_TX_Byte  in  8  byte to send.
i_TX_DV  in  1  byte valid, single-cycle pulse.
o_TX_Ready  out  1  controller accepts i_TX_DV this cycle.
o_RX_Count  out  CNT_W  0-based index of o_RX_Byte within the transaction.
o_RX_DV  out  1  received byte valid, 1-cycle pulse.
o_RX_Byte  out  8  received byte.
o_SPI_TX_Byte  out  8  to engine i_TX_Byte.
o_SPI_TX_DV  out  1  to engine i_TX_DV.
i_SPI_TX_Ready  in  1  from engine o_TX_Ready.
i_SPI_RX_DV  in  1  from engine o_RX_DV.
i_SPI_RX_Byte  in  8  from engine o_RX_Byte.
o_SPI_CS_n  out  1  chip select, active-low.

Behaviour:
- Reset (i_RST_L=0 at posedge): state IDLE, o_SPI_CS_n=1, o_SPI_TX_DV=0, o_SPI_TX_Byte=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0, internal counters=0. o_TX_Ready is forced 0 while i_RST_L=0.
- Reset mid-transaction: CS_n goes high on the same edge. Remaining bytes are discarded. There is no CS-inactive gap after reset.
- o_TX_Ready is combinational:
  - IDLE: 1.
  - XFER: 1 when remaining>0, i_SPI_TX_Ready=1 and o_SPI_TX_DV=0.
  - LEAD and GAP: 0.
- i_TX_DV while o_TX_Ready=0 is ignored, with no side effects.
- IDLE, on accept:
  - Latch count: 0 is treated as 1; values above MAX_BYTES_PER_CS clamp to MAX_BYTES_PER_CS.
  - Latch the byte into o_SPI_TX_Byte; remaining = count-1; rx_idx=0.
  - Next edge: CS_n=0 and o_SPI_TX_DV=1 for 1 cycle; go to XFER.
- XFER:
  - Each accept registers the byte, pulses o_SPI_TX_DV next cycle, and decrements remaining.
  - CS_n stays 0 indefinitely while waiting for the user; there is no timeout.
  - Track outstanding bytes as bytes sent minus i_SPI_RX_DV pulses.
  - Exit when remaining=0, outstanding=0, i_SPI_TX_Ready=1 and o_SPI_TX_DV=0. On that edge CS_n=1, load gap counter with CS_INACTIVE_CLKS, go to GAP.
- GAP: decrement each cycle; at 0 go to IDLE. CS_n is high for exactly max(CS_INACTIVE_CLKS,1) cycles before the next CS_n fall can be scheduled.
- RX path: o_RX_Byte/o_RX_DV are registered copies of the engine outputs, 1-cycle latency. o_RX_Count=rx_idx at the pulse, then rx_idx increments. RX pulses outside XFER are dropped.
- An i_SPI_RX_DV arriving on the same cycle as an accept is handled independently: both counters update.

Optional Feature:
SPI_CS_LEAD_EN.
- Defined: IDLE accept drives CS_n=0 on the next edge and enters LEAD for CS_LEAD_CLKS cycles. o_SPI_TX_DV for the first byte is asserted on the cycle after LEAD ends, then the block goes to XFER. With CS_LEAD_CLKS=0, LEAD is skipped.
- Undefined: the LEAD state and the CS_LEAD_CLKS logic are absent, and CS_n falls on the same edge as the first o_SPI_TX_DV.

Test Plan:
Common setup: MOSI looped to MISO; engine SPI_Mode=3, CLKS_PER_HALF_BIT=4; defaults otherwise.
1. Count=1, byte 0xC1 -> one CS_n low window; o_RX_Byte=0xC1, o_RX_Count=0; CS_n high for exactly 4 cycles before o_TX_Ready returns to 1.
2. Count=2, bytes 0xBE then 0xEF -> single CS_n fall and rise; RX 0xBE with count 0, 0xEF with count 1; o_TX_Ready=0 between bytes while the engine is busy.
3. Count=0 with 0x5A -> treated as 1 byte. Count=3 with MAX=2 and bytes 0x11, 0x22 -> CS_n rises after 2 bytes, and a third i_TX_DV starts a new transaction.
4. i_TX_DV with 0xFF pulsed during XFER while the engine is busy, and during GAP -> no o_SPI_TX_DV and no RX effect.
5. i_RST_L low for 2 cycles after the first byte of a count=2 transaction -> CS_n=1 on that edge, o_TX_Ready=0 during reset; then a count=1 transaction of 0xA5 returns 0xA5 with count 0.
6. SPI_CS_LEAD_EN defined, CS_LEAD_CLKS=2 -> first o_SPI_TX_DV asserted exactly 3 cycles after the CS_n fall; RX data is identical to scenario 2.
